// File: rtl/ir_sweep.sv
// IR sweep sequencer: periodically fires the IR emitters and lets them settle.
// It then converts the 8 IR channels through the A2D and publishes all readings together.
module ir_sweep #(
  parameter int PERIOD_W = 16,
  parameter int SETTLE   = 1024,
  parameter int TIMEOUT  = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cnv_cmplt_i,
  input  logic [11:0] res_i,
  output logic        strt_cnv_o,
  output logic [2:0]  chnnl_o,
  output logic        IR_en_o,
  output logic [11:0] IR_R0_o,
  output logic [11:0] IR_R1_o,
  output logic [11:0] IR_R2_o,
  output logic [11:0] IR_R3_o,
  output logic [11:0] IR_L0_o,
  output logic [11:0] IR_L1_o,
  output logic [11:0] IR_L2_o,
  output logic [11:0] IR_L3_o,
  output logic        IR_vld_o,
  output logic        sweep_err_o
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [PERIOD_W-1:0]  per_cnt_q;
  logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic [2:0]           ch_idx_q, ch_idx_d;
  logic                 strt_cnv_q, strt_cnv_d;
  logic                 IR_en_q, IR_en_d;
  logic                 IR_vld_q, IR_vld_d;
  logic                 sweep_err_q, sweep_err_d;
  logic                 tick;
  logic                 cap_en;
  logic [95:0]          ir_flat;

  assign tick   = &per_cnt_q;
  assign cap_en = (state_q == ST_WAIT) && cnv_cmplt_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      per_cnt_q    <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      ch_idx_q     <= '0;
      strt_cnv_q   <= 1'b0;
      IR_en_q      <= 1'b0;
      IR_vld_q     <= 1'b0;
      sweep_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_q + PERIOD_W'(1);
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
      ch_idx_q     <= ch_idx_d;
      strt_cnv_q   <= strt_cnv_d;
      IR_en_q      <= IR_en_d;
      IR_vld_q     <= IR_vld_d;
      sweep_err_q  <= sweep_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    to_cnt_d     = to_cnt_q;
    ch_idx_d     = ch_idx_q;
    sweep_err_d  = 1'b0;
    IR_vld_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A tick seen outside IDLE is simply dropped: that sweep is skipped.
        if (tick) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
          ch_idx_d     = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = ST_START;
        else settle_cnt_d = settle_cnt_q + SW'(1);
      end
      ST_START: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion wins over timeout when both land in the same cycle.
        if (cnv_cmplt_i) begin
          if (ch_idx_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            ch_idx_d = ch_idx_q + 3'd1;
            state_d  = ST_START;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = ST_IDLE;
          sweep_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        IR_vld_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    strt_cnv_d = (state_d == ST_START);
    IR_en_d    = (state_d == ST_SETTLE) || (state_d == ST_START) || (state_d == ST_WAIT);
  end

  // Shadow registers catch results as they arrive; outputs copy them all at once in DONE.
  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    logic [11:0] shadow_q;
    logic [11:0] ir_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        shadow_q <= '0;
        ir_q     <= '0;
      end else begin
        if (cap_en && (ch_idx_q == 3'(gi))) shadow_q <= res_i;
        if (state_q == ST_DONE) ir_q <= shadow_q;
      end
    end
    assign ir_flat[12*gi +: 12] = ir_q;
  end

  assign strt_cnv_o  = strt_cnv_q;
  assign chnnl_o     = ch_idx_q;
  assign IR_en_o     = IR_en_q;
  assign IR_vld_o    = IR_vld_q;
  assign sweep_err_o = sweep_err_q;
  assign IR_R0_o     = ir_flat[11:0];
  assign IR_R1_o     = ir_flat[23:12];
  assign IR_R2_o     = ir_flat[35:24];
  assign IR_R3_o     = ir_flat[47:36];
  assign IR_L0_o     = ir_flat[59:48];
  assign IR_L1_o     = ir_flat[71:60];
  assign IR_L2_o     = ir_flat[83:72];
  assign IR_L3_o     = ir_flat[95:84];

endmodule

// File: tb/tb_ir_sweep.sv
// Bench for ir_sweep: A2D model feeds a scoreboard of expected sweeps; a table of
// per-period scenarios plus directed spurious-completion and mid-sweep reset sequences.
module tb_ir_sweep;

  localparam int PER = 64;
  localparam int TO  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        ir_en;
  logic [11:0] ir_r0, ir_r1, ir_r2, ir_r3, ir_l0, ir_l1, ir_l2, ir_l3;
  logic        ir_vld;
  logic        sweep_err;
  logic [95:0] cur_ir;

  assign cur_ir = {ir_l3, ir_l2, ir_l1, ir_l0, ir_r3, ir_r2, ir_r1, ir_r0};

  ir_sweep #(.PERIOD_W(6), .SETTLE(8), .TIMEOUT(32)) dut (
    .clk_i(clk), .rst_i(rst), .cnv_cmplt_i(cnv_cmplt), .res_i(res),
    .strt_cnv_o(strt_cnv), .chnnl_o(chnnl), .IR_en_o(ir_en),
    .IR_R0_o(ir_r0), .IR_R1_o(ir_r1), .IR_R2_o(ir_r2), .IR_R3_o(ir_r3),
    .IR_L0_o(ir_l0), .IR_L1_o(ir_l1), .IR_L2_o(ir_l2), .IR_L3_o(ir_l3),
    .IR_vld_o(ir_vld), .sweep_err_o(sweep_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle index since reset release; tick cycles are those with cyc % 64 == 63.
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    if (rst) cyc = 0;
    else cyc++;
  end

  // A2D model configuration (written by the stimulus process only)
  int          cfg_lat    = 3;
  logic [11:0] cfg_base   = 12'h100;
  int          cfg_sp_ch  = 8;
  int          cfg_sp_lat = 0;
  int          spur_at0   = -1;
  int          spur_at1   = -1;

  logic [95:0] exp_q[$];
  logic        ign_cmplt;

  initial begin : a2d_model
    logic [95:0] sh;
    int          rem, ch;
    bit          pend, late;
    cnv_cmplt = 1'b0; res = '0; ign_cmplt = 1'b0; pend = 0; late = 0; sh = '0; rem = 0; ch = 0;
    forever begin
      @(posedge clk); #1;
      cnv_cmplt = 1'b0;
      ign_cmplt = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          rem--;
          if (rem == 0) begin
            pend      = 0;
            cnv_cmplt = 1'b1;
            res       = cfg_base + 12'(ch);
            ign_cmplt = late;
            // A reply later than the timeout window belongs to an aborted sweep.
            if (!late) begin
              sh[12*ch +: 12] = res;
              if (ch == 7) exp_q.push_back(sh);
            end
          end
        end
        if (strt_cnv) begin
          ch   = int'(chnnl);
          rem  = (ch == cfg_sp_ch) ? cfg_sp_lat : cfg_lat;
          pend = (rem != 0);
          late = (rem > TO);
        end
        if (!cnv_cmplt && (cyc == spur_at0 || cyc == spur_at1)) begin
          cnv_cmplt = 1'b1;
          res       = 12'hFFF;
          ign_cmplt = 1'b1;
        end
      end
    end
  end

  int n_vld = 0, n_err = 0, n_strt = 0;

  initial begin : monitor
    logic [95:0] last_exp;
    int  exp_ch, strt_ch, last_cmplt_cyc, last_strt_cyc;
    bit  prev_strt, prev_vld, prev_err, prev_en;
    last_exp = '0; exp_ch = 0; strt_ch = 0; last_cmplt_cyc = -100; last_strt_cyc = -100;
    prev_strt = 0; prev_vld = 0; prev_err = 0; prev_en = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_exp = '0; exp_ch = 0; last_cmplt_cyc = -100; last_strt_cyc = -100;
        prev_strt = 0; prev_vld = 0; prev_err = 0; prev_en = 0;
      end else begin
        if (cnv_cmplt && !ign_cmplt) begin
          last_cmplt_cyc = cyc;
          chk("chnnl_hold", 96'(chnnl), 96'(strt_ch));
        end
        if (strt_cnv) begin
          n_strt++;
          chk("strt_pulse", 96'(prev_strt), 96'(0));
          chk("strt_ir_en", 96'(ir_en), 96'(1));
          chk("chnnl_order", 96'(chnnl), 96'(exp_ch));
          if (exp_ch == 0) chk("tick_to_strt", 96'(cyc % PER), 96'(8));
          strt_ch = int'(chnnl);
          exp_ch = (exp_ch + 1) % 8;
          last_strt_cyc = cyc;
        end
        if (ir_vld) begin
          n_vld++;
          chk("vld_pulse", 96'(prev_vld), 96'(0));
          chk("vld_latency", 96'(cyc - last_cmplt_cyc), 96'(2));
          chk("vld_ir_en_low", 96'(ir_en), 96'(0));
          chk("sb_nonempty", 96'(exp_q.size() != 0), 96'(1));
          if (exp_q.size() != 0) last_exp = exp_q.pop_front();
        end
        chk("ir_outputs", cur_ir, last_exp);
        if (sweep_err) begin
          n_err++;
          chk("err_pulse", 96'(prev_err), 96'(0));
          chk("err_latency", 96'(cyc - last_strt_cyc), 96'(TO + 1));
          chk("err_ir_en_low", 96'(ir_en), 96'(0));
          exp_ch = 0;
        end
        if (ir_en && !prev_en) chk("ir_en_rise", 96'(cyc % PER), 96'(0));
        if (!ir_en && prev_en)
          chk("ir_en_fall", 96'(sweep_err || (cyc - 1 == last_cmplt_cyc)), 96'(1));
        prev_strt = strt_cnv; prev_vld = ir_vld; prev_err = sweep_err; prev_en = ir_en;
      end
    end
  end

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 2 * PER; i++) begin
      if (cyc % PER == ph) break;
      @(posedge clk); #1;
    end
    chk("phase_reached", 96'(cyc % PER), 96'(ph));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ir"}, cur_ir, 96'(0));
    chk({tag, "_strt"}, 96'(strt_cnv), 96'(0));
    chk({tag, "_chnnl"}, 96'(chnnl), 96'(0));
    chk({tag, "_en"}, 96'(ir_en), 96'(0));
    chk({tag, "_vld"}, 96'(ir_vld), 96'(0));
    chk({tag, "_err"}, 96'(sweep_err), 96'(0));
  endtask

  typedef struct {
    int          lat;
    logic [11:0] base;
    int          sp_ch;
    int          sp_lat;
    int          nper;
    int          exp_vld;
    int          exp_err;
    int          exp_strt;
  } row_t;

  row_t rows[9];

  task automatic run_window(input string tag, input int nper, input int ev, input int ee, input int es);
    int v0, e0, s0;
    v0 = n_vld; e0 = n_err; s0 = n_strt;
    repeat (PER * nper) @(posedge clk);
    #1;
    chk({tag, "_vld_count"}, 96'(n_vld - v0), 96'(ev));
    chk({tag, "_err_count"}, 96'(n_err - e0), 96'(ee));
    chk({tag, "_strt_count"}, 96'(n_strt - s0), 96'(es));
    $display("%s: vld=%0d err=%0d strt=%0d", tag, n_vld - v0, n_err - e0, n_strt - s0);
  endtask

  initial begin
    // lat, base, special ch, special lat (0 = never), periods, vld, err, strt
    rows[0] = '{3,  12'h100, 8, 0,  1, 1, 0, 8};  // nominal
    rows[1] = '{3,  12'h200, 8, 0,  1, 1, 0, 8};  // back-to-back, new values
    rows[2] = '{5,  12'h300, 8, 0,  1, 1, 0, 8};
    rows[3] = '{3,  12'h400, 5, 0,  1, 0, 1, 6};  // withhold ch5 -> timeout
    rows[4] = '{3,  12'h500, 8, 0,  1, 1, 0, 8};  // recovers next tick
    rows[5] = '{3,  12'h600, 2, 32, 2, 1, 0, 8};  // reply on last WAIT cycle accepted
    rows[6] = '{3,  12'h700, 7, 33, 2, 0, 1, 8};  // reply one cycle too late on ch7
    rows[7] = '{10, 12'h800, 8, 0,  2, 1, 0, 8};  // slow A2D, mid-sweep tick skipped
    rows[8] = '{1,  12'h900, 8, 0,  1, 1, 0, 8};  // fastest A2D

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    wait_phase(62);
    for (int r = 0; r < 9; r++) begin
      cfg_lat = rows[r].lat; cfg_base = rows[r].base;
      cfg_sp_ch = rows[r].sp_ch; cfg_sp_lat = rows[r].sp_lat;
      run_window($sformatf("row%0d", r), rows[r].nper, rows[r].exp_vld, rows[r].exp_err, rows[r].exp_strt);
    end

    // Spurious completions in IDLE (tick cycle) and in SETTLE must be ignored.
    wait_phase(62);
    cfg_lat = 3; cfg_base = 12'hA00; cfg_sp_ch = 8; cfg_sp_lat = 0;
    spur_at0 = cyc + 1;
    spur_at1 = cyc + 5;
    run_window("spurious", 1, 1, 0, 8);

    // Asynchronous reset in the middle of a WAIT.
    cfg_base = 12'hB00;
    wait_phase(62);
    wait_phase(23);
    chk("pre_rst_ir_en", 96'(ir_en), 96'(1));
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_window("post_reset", 2, 1, 0, 8);

    chk("sb_drained", 96'(exp_q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
